barrett_arbiter: RTL and testbench

// - Shares one combinational barrett reducer between NREQ requesters (decap polynomial units).
// - Per-requester valid/ready request port; one registered result stream tagged with requester ID.
// - Pipeline: arbitration -> operand register -> barrett datapath -> result register.
// - Throughput is one reduction per cycle; modulus configuration is shared by all requesters.

---
 rtl/barrett_pkg.sv | 28 ++
 rtl/barrett_arbiter_if.sv | 46 ++++
 rtl/barrett_reduce.sv | 57 +++++
 rtl/barrett_rr_pick.sv | 58 +++++
 rtl/barrett_arbiter.sv | 162 ++++++++++++++++
 tb/tb_barrett_arbiter.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/barrett_pkg.sv
// -----------------------------------------------------------------------------
// barrett_pkg
// Shared constants for the Barrett reducer arbiter:
//   - default modulus / shift widths
//   - sntrup761 modulus Q and floor(2^27 / Q)
//   - id_width(): requester-tag width (never less than 1 bit)
// -----------------------------------------------------------------------------
package barrett_pkg;

    localparam int unsigned M0LEN_DEF = 32'd14;
    localparam int unsigned SHIFT_DEF = 32'd27;

    // sntrup761 modulus and its Barrett inverse for a shift of 27
    localparam logic [13:0] SNTRUP_Q      = 14'd4591;
    localparam logic [26:0] SNTRUP_QINV27 = 27'd29234;

    // Tag width for n requesters; a single-bit tag is kept for n <= 2
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        if (n <= 32'd2) begin
            w = 32'd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/barrett_arbiter_if.sv
// -----------------------------------------------------------------------------
// barrett_arbiter_if
// Bundles the modulus configuration, the NREQ request ports and the tagged
// result stream of barrett_arbiter.
//   slave  : view used by the arbiter (config/requests in, results out)
//   master : view used by requesters/sink/testbench
// Signals:
//   m0, m0_inverse           shared modulus and floor(2^SHIFT / m0)
//   req_valid/req_ready      per-requester handshake
//   req_dividend             dividend i at [i*2*M0LEN +: 2*M0LEN]
//   out_valid/out_ready      result handshake
//   out_id, out_quotient, out_remainder   tagged result
//   busy                     any pipeline stage holds valid data
// -----------------------------------------------------------------------------
interface barrett_arbiter_if
    import barrett_pkg::*;
#(
    parameter int unsigned NREQ  = 32'd4,
    parameter int unsigned M0LEN = M0LEN_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
);
    localparam int unsigned IDW = id_width(NREQ);

    logic [M0LEN-1:0]        m0;
    logic [SHIFT-1:0]        m0_inverse;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*2*M0LEN-1:0] req_dividend;
    logic [NREQ-1:0]         req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDW-1:0]          out_id;
    logic [M0LEN-1:0]        out_quotient;
    logic [M0LEN-1:0]        out_remainder;
    logic                    busy;

    modport slave (
        input  m0, m0_inverse, req_valid, req_dividend, out_ready,
        output req_ready, out_valid, out_id, out_quotient, out_remainder, busy
    );

    modport master (
        output m0, m0_inverse, req_valid, req_dividend, out_ready,
        input  req_ready, out_valid, out_id, out_quotient, out_remainder, busy
    );

endinterface

// File: rtl/barrett_reduce.sv
// -----------------------------------------------------------------------------
// barrett_reduce
// Combinational Barrett reduction of a 2*M0LEN-bit dividend by m0.
//   dividend_i  [2*M0LEN]  value to reduce, exact for dividend < m0*2^M0LEN
//   m0_i        [M0LEN]    modulus
//   m0_inv_i    [SHIFT]    floor(2^SHIFT / m0)
//   quotient_o  [M0LEN]    floor(dividend / m0)
//   remainder_o [M0LEN]    dividend mod m0
// -----------------------------------------------------------------------------
module barrett_reduce #(
    parameter int unsigned M0LEN = 32'd14,
    parameter int unsigned SHIFT = 32'd27
) (
    input  logic [2*M0LEN-1:0] dividend_i,
    input  logic [M0LEN-1:0]   m0_i,
    input  logic [SHIFT-1:0]   m0_inv_i,
    output logic [M0LEN-1:0]   quotient_o,
    output logic [M0LEN-1:0]   remainder_o
);

    localparam int unsigned DW = 2 * M0LEN;
    localparam int unsigned PW = DW + SHIFT;

    logic [PW-1:0] prod_s;
    logic [DW-1:0] m0_w_s;
    logic [DW-1:0] q0_s, q1_s, q2_s;
    logic [DW-1:0] r0_s, r1_s, r2_s;

    // Estimate the quotient, then fix it up. Within the input contract the
    // estimate undershoots by at most 2, so two conditional subtractions suffice.
    always_comb begin
        m0_w_s = DW'(m0_i);
        prod_s = PW'(dividend_i) * PW'(m0_inv_i);
        q0_s   = DW'(prod_s >> SHIFT);
        r0_s   = dividend_i - (q0_s * m0_w_s);

        if (r0_s >= m0_w_s) begin
            r1_s = r0_s - m0_w_s;
            q1_s = q0_s + DW'(1);
        end else begin
            r1_s = r0_s;
            q1_s = q0_s;
        end

        if (r1_s >= m0_w_s) begin
            r2_s = r1_s - m0_w_s;
            q2_s = q1_s + DW'(1);
        end else begin
            r2_s = r1_s;
            q2_s = q1_s;
        end

        quotient_o  = M0LEN'(q2_s);
        remainder_o = M0LEN'(r2_s);
    end

endmodule

// File: rtl/barrett_rr_pick.sv
// -----------------------------------------------------------------------------
// barrett_rr_pick
// Rotating priority picker: grants the first set bit of valid_i at or after
// ptr_i (wrapping). Rotate -> lowest-set-bit priority -> unrotate.
//   valid_i  [NREQ]  request vector
//   ptr_i    [IDW]   priority pointer, must be < NREQ
//   grant_o  [NREQ]  one-hot grant, zero when nothing is valid
//   idx_o    [IDW]   index of the granted requester
//   any_o            some requester is valid
// -----------------------------------------------------------------------------
module barrett_rr_pick #(
    parameter int unsigned NREQ = 32'd4,
    parameter int unsigned IDW  = 32'd2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [IDW-1:0]    off_s;
    logic [IDW:0]      sum_s;

    // Rotate so the pointer position sits at bit 0, then find the lowest set bit
    always_comb begin
        dbl_s = {valid_i, valid_i} >> ptr_i;
        rot_s = dbl_s[NREQ-1:0];
        off_s = {IDW{1'b0}};
        any_o = 1'b0;
        // Descending scan so the lowest offset is the last one written
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = IDW'(k);
                any_o = 1'b1;
            end else begin
                off_s = off_s;
                any_o = any_o;
            end
        end
    end

    // Unrotate: index = (ptr + offset) mod NREQ, then decode to one-hot
    always_comb begin
        sum_s = {1'b0, ptr_i} + {1'b0, off_s};
        if (sum_s >= (IDW+1)'(NREQ)) begin
            idx_o = IDW'(sum_s - (IDW+1)'(NREQ));
        end else begin
            idx_o = sum_s[IDW-1:0];
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_o[i] = any_o & (idx_o == IDW'(i));
        end
    end

endmodule

// File: rtl/barrett_arbiter.sv
// -----------------------------------------------------------------------------
// barrett_arbiter
// Shares one combinational Barrett reducer between NREQ requesters.
// Pipeline: arbitration -> S1 operand register -> reducer -> S2 result register.
// One reduction per cycle; the whole pipe freezes while the result is stalled.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; drops in-flight results
//   bus   barrett_arbiter_if.slave (config, request ports, result stream, busy)
// Build option:
//   BARRETT_ARB_RR_EN  defined   -> round-robin, pointer moves past last winner
//                      undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module barrett_arbiter
    import barrett_pkg::*;
#(
    parameter int unsigned NREQ  = 32'd4,
    parameter int unsigned M0LEN = M0LEN_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input logic              clk,
    input logic              rst,
    barrett_arbiter_if.slave bus
);

    localparam int unsigned IDW = id_width(NREQ);
    localparam int unsigned DW  = 2 * M0LEN;

    logic             stall_s;
    logic             any_s;
    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   pick_idx_s;
    logic [IDW-1:0]   ptr_s;
    logic [DW-1:0]    sel_div_s;
    logic [M0LEN-1:0] red_quot_s;
    logic [M0LEN-1:0] red_rem_s;

    logic             s1_valid_q, s1_valid_d;
    logic [IDW-1:0]   s1_id_q,    s1_id_d;
    logic [DW-1:0]    s1_div_q,   s1_div_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IDW-1:0]   s2_id_q,    s2_id_d;
    logic [M0LEN-1:0] s2_quot_q,  s2_quot_d;
    logic [M0LEN-1:0] s2_rem_q,   s2_rem_d;

    assign stall_s = s2_valid_q & ~bus.out_ready;

    barrett_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_s),
        .grant_o (grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (any_s)
    );

    // Grants are withheld during reset so nothing is consumed that S1 would drop
    assign bus.req_ready = grant_s & {NREQ{~stall_s & ~rst}};

    // Route the granted requester's dividend (grant is one-hot or zero)
    always_comb begin
        sel_div_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_div_s = sel_div_s | (bus.req_dividend[i*DW +: DW] & {DW{grant_s[i]}});
        end
    end

    barrett_reduce #(
        .M0LEN (M0LEN),
        .SHIFT (SHIFT)
    ) u_reduce (
        .dividend_i  (s1_div_q),
        .m0_i        (bus.m0),
        .m0_inv_i    (bus.m0_inverse),
        .quotient_o  (red_quot_s),
        .remainder_o (red_rem_s)
    );

    // Next state of both stages: advance together unless the result is stalled
    always_comb begin
        if (!stall_s) begin
            s1_valid_d = any_s;
            s1_id_d    = pick_idx_s;
            s1_div_d   = sel_div_s;
            s2_valid_d = s1_valid_q;
            s2_id_d    = s1_id_q;
            s2_quot_d  = red_quot_s;
            s2_rem_d   = red_rem_s;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_id_d    = s1_id_q;
            s1_div_d   = s1_div_q;
            s2_valid_d = s2_valid_q;
            s2_id_d    = s2_id_q;
            s2_quot_d  = s2_quot_q;
            s2_rem_d   = s2_rem_q;
        end
    end

    // Operand and result stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= {IDW{1'b0}};
            s1_div_q   <= {DW{1'b0}};
            s2_valid_q <= 1'b0;
            s2_id_q    <= {IDW{1'b0}};
            s2_quot_q  <= {M0LEN{1'b0}};
            s2_rem_q   <= {M0LEN{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_div_q   <= s1_div_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_quot_q  <= s2_quot_d;
            s2_rem_q   <= s2_rem_d;
        end
    end

`ifdef BARRETT_ARB_RR_EN
    logic           xfer_s;
    logic [IDW-1:0] ptr_q, ptr_d;

    assign xfer_s = any_s & ~stall_s & ~rst;

    // Pointer moves just past the requester that transferred, with wrap
    always_comb begin
        if (xfer_s) begin
            if (pick_idx_s == IDW'(NREQ - 1)) begin
                ptr_d = {IDW{1'b0}};
            end else begin
                ptr_d = pick_idx_s + IDW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {IDW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`else
    assign ptr_s = {IDW{1'b0}};
`endif

    assign bus.out_valid     = s2_valid_q;
    assign bus.out_id        = s2_id_q;
    assign bus.out_quotient  = s2_quot_q;
    assign bus.out_remainder = s2_rem_q;
    assign bus.busy          = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_barrett_arbiter.sv
// -----------------------------------------------------------------------------
// tb_barrett_arbiter
// Directed bench for barrett_arbiter. A queue-based model predicts grants,
// output stream and busy from the arbitration and latency rules, checked on
// every falling edge; literal expectations pin single results, boundaries,
// grant order, stall behaviour and reset recovery.
// -----------------------------------------------------------------------------
module tb_barrett_arbiter;
    import barrett_pkg::*;

    localparam int NREQ  = 4;
    localparam int M0LEN = 14;
    localparam int SHIFT = 27;
    localparam int DW    = 2 * M0LEN;
    localparam longint M0_VAL = 4591;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    barrett_arbiter_if #(.NREQ(NREQ), .M0LEN(M0LEN), .SHIFT(SHIFT)) bus();

    barrett_arbiter #(.NREQ(NREQ), .M0LEN(M0LEN), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     id;
        longint q;
        longint r;
        int     age;   // clock edges since acceptance
    } ent_t;

    ent_t pipe[$];
    int   mptr     = 0;
    bit   rst_seen = 1'b1;

    function automatic int exp_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int              g;
        bit              mov;
        bit              mstall;
        logic [NREQ-1:0] exp_rdy;
        longint          d;
        ent_t            e;

        mov    = (pipe.size() > 0) && (pipe[0].age >= 2);
        mstall = mov && !bus.out_ready;
        g      = exp_pick(bus.req_valid, mptr);
        exp_rdy = '0;
        if (!rst && !mstall && g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready", longint'(bus.req_ready), longint'(exp_rdy));
        chk("out_valid", longint'(bus.out_valid), longint'(mov));
        chk("busy", longint'(bus.busy), longint'(pipe.size() > 0));
        if (mov) begin
            chk("out_id", longint'(bus.out_id), longint'(pipe[0].id));
            chk("out_quotient", longint'(bus.out_quotient), pipe[0].q);
            chk("out_remainder", longint'(bus.out_remainder), pipe[0].r);
        end
        if (rst_seen) begin
            chk("rst_out_id", longint'(bus.out_id), 0);
            chk("rst_out_quotient", longint'(bus.out_quotient), 0);
            chk("rst_out_remainder", longint'(bus.out_remainder), 0);
        end

        // advance the model over the coming rising edge
        if (rst) begin
            pipe.delete();
            mptr     = 0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (!mstall) begin
                if (mov) void'(pipe.pop_front());
                foreach (pipe[i]) pipe[i].age++;
                if (g >= 0) begin
                    d     = longint'(bus.req_dividend[g*DW +: DW]);
                    e.id  = g;
                    e.q   = d / M0_VAL;
                    e.r   = d % M0_VAL;
                    e.age = 1;
                    pipe.push_back(e);
`ifdef BARRETT_ARB_RR_EN
                    mptr = (g + 1) % NREQ;
`endif
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic rand_divs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_dividend[i*DW +: DW] = DW'($urandom_range(0, 4591*16384 - 1));
        end
    endtask

    task automatic lit_single(input int id, input logic [DW-1:0] div,
                              input longint eq, input longint er);
        int n;
        @(posedge clk); #1;
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_dividend[id*DW +: DW] = div;
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lit_latency", n, 2);
        chk("lit_id", longint'(bus.out_id), id);
        chk("lit_quotient", longint'(bus.out_quotient), eq);
        chk("lit_remainder", longint'(bus.out_remainder), er);
    endtask

    initial begin
        logic [NREQ-1:0]  one;
        logic [NREQ-1:0]  exp_g;
        logic [1:0]       cap_id;
        logic [M0LEN-1:0] cap_q;
        logic [M0LEN-1:0] cap_r;

        one              = 4'b0001;
        rst              = 1'b1;
        bus.m0           = SNTRUP_Q;
        bus.m0_inverse   = SNTRUP_QINV27;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single request and arithmetic boundaries
        lit_single(2, 28'd10000000, 2178, 802);
        lit_single(0, 28'd0, 0, 0);
        lit_single(1, 28'd4590, 0, 4590);
        lit_single(3, 28'd4591, 1, 0);
        lit_single(2, 28'd21077280, 4590, 4590);

        // fresh pointer before the contention run
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // all requesters valid: grant order
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            rand_divs();
            #1;
`ifdef BARRETT_ARB_RR_EN
            exp_g = one << (k % NREQ);
`else
            exp_g = one;
`endif
            chk("grant_seq", longint'(bus.req_ready), longint'(exp_g));
            @(posedge clk); #1;
        end

        // stall with a full pipe
        bus.out_ready = 1'b0;
        #1;
        chk("stall_out_valid", longint'(bus.out_valid), 1);
        cap_id = bus.out_id;
        cap_q  = bus.out_quotient;
        cap_r  = bus.out_remainder;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            rand_divs();
            chk("stall_req_ready", longint'(bus.req_ready), 0);
            chk("stall_valid", longint'(bus.out_valid), 1);
            chk("stall_id", longint'(bus.out_id), longint'(cap_id));
            chk("stall_q", longint'(bus.out_quotient), longint'(cap_q));
            chk("stall_r", longint'(bus.out_remainder), longint'(cap_r));
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            rand_divs();
        end
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_busy", longint'(bus.busy), 0);
        chk("drain_model_empty", longint'(pipe.size()), 0);

        // reset while busy
        bus.req_valid = 4'hF;
        repeat (2) begin
            rand_divs();
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", longint'(bus.busy), 1);
        rst           = 1'b1;
        bus.req_valid = 4'b1010;
        @(posedge clk); #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_req_ready", longint'(bus.req_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", longint'(bus.req_ready), 4'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_busy", longint'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
